// File: rtl/riscm_pkg.sv
// rtl/riscm_pkg.sv - shared constants and encodings for the RISC machine front end
//
// Purpose: default widths, opcode/cond encodings, one-hot register-field
// selects and memory command codes shared by the fetch/decode unit and
// its consumers.
package riscm_pkg;

  localparam int          ADDR_W_DEF   = 9;
  localparam logic [8:0]  RESET_PC_DEF = 9'd0;

  typedef enum logic [2:0] {
    OPC_B    = 3'b001,
    OPC_LDR  = 3'b011,
    OPC_STR  = 3'b100,
    OPC_ALU  = 3'b101,
    OPC_MOV  = 3'b110,
    OPC_HALT = 3'b111
  } opcode_e;

  typedef enum logic [2:0] {
    COND_B   = 3'b000,
    COND_BEQ = 3'b001,
    COND_BNE = 3'b010,
    COND_BLT = 3'b011,
    COND_BLE = 3'b100
  } cond_e;

  localparam logic [2:0] NSEL_RN = 3'b001;
  localparam logic [2:0] NSEL_RD = 3'b010;
  localparam logic [2:0] NSEL_RM = 3'b100;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_READ  = 2'b01,
    MEM_WRITE = 2'b10
  } mem_cmd_e;

endpackage

// File: rtl/instr_decoder.sv
// rtl/instr_decoder.sv - combinational instruction register field decoder
//
// Purpose: split the 16-bit IR into controller and datapath fields.
// Ports:
//   ir       in  16  instruction register contents
//   nsel     in  3   one-hot register-field select (Rn/Rd/Rm)
//   opcode   out 3   ir[15:13]
//   op       out 2   ir[12:11]
//   cond     out 3   ir[10:8]
//   readnum  out 3   selected register number
//   writenum out 3   selected register number (same as readnum)
//   shift    out 2   ir[4:3], zero for LDR/STR
//   ALUop    out 2   ir[12:11]
//   sximm5   out 16  sign-extended ir[4:0]
//   sximm8   out 16  sign-extended ir[7:0]
module instr_decoder
  import riscm_pkg::*;
(
  input  logic [15:0] ir,
  input  logic [2:0]  nsel,
  output logic [2:0]  opcode,
  output logic [1:0]  op,
  output logic [2:0]  cond,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm5,
  output logic [15:0] sximm8
);

  logic [2:0] w_regnum;
  logic       w_is_mem;

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign ALUop  = ir[12:11];
  assign cond   = ir[10:8];
  assign sximm5 = {{11{ir[4]}}, ir[4:0]};
  assign sximm8 = {{8{ir[7]}}, ir[7:0]};

  // LDR/STR reuse ir[4:3] as part of the offset, so the shifter must idle.
  assign w_is_mem = (ir[15:13] == OPC_LDR) || (ir[15:13] == OPC_STR);
  assign shift    = w_is_mem ? 2'b00 : ir[4:3];

  // Non-one-hot selects (including 000) yield register 0.
  always_comb begin
    w_regnum = 3'b000;
    case (nsel)
      NSEL_RN: w_regnum = ir[10:8];
      NSEL_RD: w_regnum = ir[7:5];
      NSEL_RM: w_regnum = ir[2:0];
      default: w_regnum = 3'b000;
    endcase
  end

  assign readnum  = w_regnum;
  assign writenum = w_regnum;

endmodule

// File: rtl/fetch_decode_unit.sv
// rtl/fetch_decode_unit.sv - PC, data-address and IR registers with address mux and decode
//
// Purpose: instruction fetch/decode front end sequenced by the controller FSM.
// Ports:
//   clk, reset (async active-low)
//   mdata        in  16      memory read data for the IR
//   datapath_out in  16      branch target / data address source
//   reset_pc, load_pc, PC_sel, load_addr, addr_sel, load_ir  in 1
//   nsel         in  3       one-hot register-field select
//   mem_addr     out ADDR_W  addr_sel ? pc : data address
//   pc           out ADDR_W  program counter
//   ir           out 16      instruction register
//   opcode/op/cond/readnum/writenum/shift/ALUop/sximm5/sximm8  decoded fields
module fetch_decode_unit
  import riscm_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       mdata,
  input  logic [15:0]       datapath_out,
  input  logic              reset_pc,
  input  logic              load_pc,
  input  logic              PC_sel,
  input  logic              load_addr,
  input  logic              addr_sel,
  input  logic              load_ir,
  input  logic [2:0]        nsel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] pc,
  output logic [15:0]       ir,
  output logic [2:0]        opcode,
  output logic [1:0]        op,
  output logic [2:0]        cond,
  output logic [2:0]        readnum,
  output logic [2:0]        writenum,
  output logic [1:0]        shift,
  output logic [1:0]        ALUop,
  output logic [15:0]       sximm5,
  output logic [15:0]       sximm8
);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_data_addr;
  logic [15:0]       r_ir;
  logic [ADDR_W-1:0] w_dp_addr;
  logic              w_unused_dp_hi;

  assign w_dp_addr      = datapath_out[ADDR_W-1:0];
  assign w_unused_dp_hi = ^datapath_out[15:ADDR_W];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc        <= RESET_PC;
      r_data_addr <= '0;
      r_ir        <= '0;
    end else begin
      // reset_pc beats a branch, a branch beats the increment.
      if (reset_pc)
        r_pc <= RESET_PC;
      else if (PC_sel)
        r_pc <= w_dp_addr;
      else if (load_pc)
        r_pc <= r_pc + ADDR_W'(1);

      if (load_addr)
        r_data_addr <= w_dp_addr;

      if (load_ir)
        r_ir <= mdata;
    end
  end

  assign pc       = r_pc;
  assign ir       = r_ir;
  assign mem_addr = addr_sel ? r_pc : r_data_addr;

  instr_decoder u_instr_decoder (
    .ir       (r_ir),
    .nsel     (nsel),
    .opcode   (opcode),
    .op       (op),
    .cond     (cond),
    .readnum  (readnum),
    .writenum (writenum),
    .shift    (shift),
    .ALUop    (ALUop),
    .sximm5   (sximm5),
    .sximm8   (sximm8)
  );

endmodule

// File: tb/tb_fetch_decode_unit.sv
// tb/tb_fetch_decode_unit.sv - self-checking bench for fetch_decode_unit
module tb_fetch_decode_unit;

  logic        clk;
  logic        reset;
  logic [15:0] mdata;
  logic [15:0] datapath_out;
  logic        reset_pc, load_pc, PC_sel, load_addr, addr_sel, load_ir;
  logic [2:0]  nsel;
  logic [8:0]  mem_addr, pc;
  logic [15:0] ir;
  logic [2:0]  opcode, cond, readnum, writenum;
  logic [1:0]  op, shift, ALUop;
  logic [15:0] sximm5, sximm8;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_decode_unit #(.ADDR_W(9), .RESET_PC(9'd0)) dut (
    .clk(clk), .reset(reset), .mdata(mdata), .datapath_out(datapath_out),
    .reset_pc(reset_pc), .load_pc(load_pc), .PC_sel(PC_sel),
    .load_addr(load_addr), .addr_sel(addr_sel), .load_ir(load_ir),
    .nsel(nsel), .mem_addr(mem_addr), .pc(pc), .ir(ir),
    .opcode(opcode), .op(op), .cond(cond), .readnum(readnum),
    .writenum(writenum), .shift(shift), .ALUop(ALUop),
    .sximm5(sximm5), .sximm8(sximm8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] mdata;
    logic [2:0]  nsel;
    logic [2:0]  opcode;
    logic [1:0]  op;
    logic [2:0]  cond;
    logic [2:0]  regnum;
    logic [1:0]  shift;
    logic [15:0] sx5;
    logic [15:0] sx8;
  } vec_t;

  vec_t tbl[7];
  vec_t sb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ctrl();
    reset_pc = 0; load_pc = 0; PC_sel = 0; load_addr = 0; load_ir = 0;
  endtask

  logic [8:0]  save_pc;
  logic [15:0] save_ir;
  logic [8:0]  save_da;
  vec_t        v;

  initial begin
    reset = 0; mdata = 0; datapath_out = 0; addr_sel = 1; nsel = 3'b000;
    idle_ctrl();

    // Reset state, observed before the first clock edge.
    #2;
    chk("rst_pc", pc, 9'd0);
    chk("rst_ir", ir, 16'h0000);
    chk("rst_memaddr_pc", mem_addr, 9'd0);
    addr_sel = 0; #1;
    chk("rst_memaddr_da", mem_addr, 9'd0);
    chk("rst_opcode", opcode, 3'd0);
    chk("rst_sx8", sximm8, 16'h0);
    tick();
    reset = 1;
    tick();

    // Decode vectors, pushed to the scoreboard on load, popped after the edge.
    tbl[0] = '{16'hD2A5, 3'b001, 3'b110, 2'b10, 3'b010, 3'd2, 2'b00, 16'h0005, 16'hFFA5};
    tbl[1] = '{16'h6151, 3'b010, 3'b011, 2'b00, 3'b001, 3'd2, 2'b00, 16'hFFF1, 16'h0051};
    tbl[2] = '{16'hA0FB, 3'b100, 3'b101, 2'b00, 3'b000, 3'd3, 2'b11, 16'hFFFB, 16'hFFFB};
    tbl[3] = '{16'h8A6E, 3'b001, 3'b100, 2'b01, 3'b010, 3'd2, 2'b00, 16'h000E, 16'h006E};
    tbl[4] = '{16'hB8E9, 3'b010, 3'b101, 2'b11, 3'b000, 3'd7, 2'b01, 16'h0009, 16'hFFE9};
    tbl[5] = '{16'h2345, 3'b011, 3'b001, 2'b00, 3'b011, 3'd0, 2'b00, 16'h0005, 16'h0045};
    tbl[6] = '{16'hE000, 3'b000, 3'b111, 2'b00, 3'b000, 3'd0, 2'b00, 16'h0000, 16'h0000};

    for (int i = 0; i < 7; i++) begin
      mdata = tbl[i].mdata;
      nsel  = tbl[i].nsel;
      load_ir = 1;
      sb_q.push_back(tbl[i]);
      tick();
      load_ir = 0;
      mdata = 16'h0000;
      if (sb_q.size() == 0) begin
        chk("sb_empty", 32'd1, 32'd0);
      end else begin
        v = sb_q.pop_front();
        chk($sformatf("v%0d_ir", i), ir, v.mdata);
        chk($sformatf("v%0d_opcode", i), opcode, v.opcode);
        chk($sformatf("v%0d_op", i), op, v.op);
        chk($sformatf("v%0d_aluop", i), ALUop, v.op);
        chk($sformatf("v%0d_cond", i), cond, v.cond);
        chk($sformatf("v%0d_readnum", i), readnum, v.regnum);
        chk($sformatf("v%0d_writenum", i), writenum, v.regnum);
        chk($sformatf("v%0d_shift", i), shift, v.shift);
        chk($sformatf("v%0d_sx5", i), sximm5, v.sx5);
        chk($sformatf("v%0d_sx8", i), sximm8, v.sx8);
      end
    end

    // LDR address path: load_addr then addr_sel=0.
    datapath_out = 16'h01F5; load_addr = 1;
    tick();
    idle_ctrl();
    addr_sel = 0; #1;
    chk("ldr_memaddr", mem_addr, 9'h1F5);

    // load_addr and PC_sel together both take the same datapath_out.
    datapath_out = 16'hFE37; load_addr = 1; PC_sel = 1;
    tick();
    idle_ctrl();
    chk("dual_pc", pc, 9'h037);
    addr_sel = 0; #1;
    chk("dual_da", mem_addr, 9'h037);

    // Fetch sequence: IF1, IF2 (load_ir), UpdatePC.
    addr_sel = 1; #1;
    chk("if1_memaddr", mem_addr, 9'h037);
    mdata = 16'hA8E2; load_ir = 1;
    tick();
    idle_ctrl();
    load_pc = 1;
    tick();
    idle_ctrl();
    chk("fetch_pc", pc, 9'h038);
    chk("fetch_opcode", opcode, 3'b101);
    chk("fetch_op", op, 2'b01);

    // load_ir together with load_pc.
    mdata = 16'h1234; load_ir = 1; load_pc = 1;
    tick();
    idle_ctrl();
    chk("irpc_ir", ir, 16'h1234);
    chk("irpc_pc", pc, 9'h039);

    // PC wrap 511 -> 0.
    datapath_out = 16'h01FF; PC_sel = 1;
    tick();
    idle_ctrl();
    chk("wrap_pre", pc, 9'h1FF);
    load_pc = 1;
    tick();
    idle_ctrl();
    chk("wrap_pc", pc, 9'h000);

    // Branch priority.
    datapath_out = 16'h0123; PC_sel = 1;
    tick();
    idle_ctrl();
    chk("br_pc", pc, 9'h123);
    datapath_out = 16'h0077; PC_sel = 1; reset_pc = 1; load_pc = 1;
    tick();
    idle_ctrl();
    chk("br_resetpc", pc, 9'h000);
    datapath_out = 16'h0010; PC_sel = 1;
    tick();
    chk("br_hold1", pc, 9'h010);
    datapath_out = 16'h0020;
    tick();
    idle_ctrl();
    chk("br_hold2", pc, 9'h020);

    // Illegal nsel.
    mdata = 16'hD7FF; load_ir = 1;
    tick();
    idle_ctrl();
    nsel = 3'b011; #1;
    chk("nsel_011", readnum, 3'd0);
    nsel = 3'b110; #1;
    chk("nsel_110", writenum, 3'd0);
    nsel = 3'b100; #1;
    chk("nsel_rm", readnum, 3'd7);

    // Hold: no loads for 10 cycles while inputs wander.
    save_pc = 9'h020; save_ir = 16'hD7FF;
    addr_sel = 0; #1;
    save_da = 9'h037;
    chk("hold_da_pre", mem_addr, save_da);
    for (int i = 0; i < 10; i++) begin
      mdata = 16'($urandom);
      datapath_out = 16'($urandom);
      tick();
    end
    chk("hold_pc", pc, save_pc);
    chk("hold_ir", ir, save_ir);
    chk("hold_da", mem_addr, save_da);

    // Mid-run async reset with pc=0x0A5, IR=FFFF; PC load pending at reset.
    datapath_out = 16'h00A5; PC_sel = 1; mdata = 16'hFFFF; load_ir = 1;
    tick();
    idle_ctrl();
    chk("mid_pre_pc", pc, 9'h0A5);
    chk("mid_pre_ir", ir, 16'hFFFF);
    load_pc = 1; load_addr = 1; datapath_out = 16'h0155;
    addr_sel = 1;
    #2;
    reset = 0;
    #1;
    chk("mid_rst_pc", pc, 9'd0);
    chk("mid_rst_ir", ir, 16'h0000);
    chk("mid_rst_memaddr", mem_addr, 9'd0);
    chk("mid_rst_sx8", sximm8, 16'h0000);
    idle_ctrl();
    tick();
    reset = 1;
    tick();
    chk("post_rst_pc", pc, 9'd0);
    addr_sel = 0; #1;
    chk("post_rst_da", mem_addr, 9'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_decode_unit.md
# fetch_decode_unit

Instruction-fetch and decode front end of the RISC machine. Holds the program counter, the data-address register and the instruction register, drives the 9-bit memory address, and decodes the current instruction into the fields the controller and datapath consume (`opcode`, `op`, `cond`, register numbers, immediates, shift). It sits directly upstream of the controller FSM and is sequenced entirely by that FSM's `reset_pc`, `load_pc`, `PC_sel`, `load_addr`, `addr_sel`, `load_ir` and `nsel` outputs.

## Interface
- `ADDR_W`, 9: memory address / PC width.
- `RESET_PC`, 0: PC value loaded by `reset` and by `reset_pc`.
- `clk` in 1: single clock; all registers update on the rising edge.
- `reset` in 1: asynchronous, active-low; clears every register while low.
- `mdata` in 16: memory read data, captured into the IR.
- `datapath_out` in 16: datapath result; bits [ADDR_W-1:0] feed the PC (branch target) and the data-address register.
- `reset_pc`, `load_pc`, `PC_sel` in 1 each: PC controls.
- `load_addr` in 1: load data-address register.
- `addr_sel` in 1: 1 selects PC, 0 selects data address onto `mem_addr`.
- `load_ir` in 1: load IR from `mdata`.
- `nsel` in 3: one-hot register-field select (001 Rn, 010 Rd, 100 Rm).
- `mem_addr` out ADDR_W: memory address.
- `pc` out ADDR_W: current PC (datapath vsel=01 source).
- `ir` out 16: instruction register.
- `opcode` out 3, `op` out 2, `cond` out 3: to controller.
- `readnum`, `writenum` out 3: selected register number.
- `shift` out 2, `ALUop` out 2, `sximm5` out 16, `sximm8` out 16: to datapath.

## Operation
- PC register: written on a clock edge when `reset_pc | load_pc | PC_sel`. Next-value priority: `reset_pc` → RESET_PC; else `PC_sel` → `datapath_out[ADDR_W-1:0]`; else `pc + 1`, mod 2^ADDR_W (511 + 1 wraps to 0).
- Data-address register: loads `datapath_out[ADDR_W-1:0]` when `load_addr`; holds otherwise.
- IR: loads `mdata` when `load_ir`; holds otherwise.
- `mem_addr = addr_sel ? pc : data_addr`; combinational.
- Decode, combinational from IR only:
  - `opcode = ir[15:13]`, `op = ALUop = ir[12:11]`, `cond = ir[10:8]`.
  - Rn = `ir[10:8]`, Rd = `ir[7:5]`, Rm = `ir[2:0]`.
  - `sximm5` = sign-extended `ir[4:0]`; `sximm8` = sign-extended `ir[7:0]`.
  - `shift = ir[4:3]`, forced to 00 when opcode is 011 (LDR) or 100 (STR).
  - `readnum = writenum` = Rn/Rd/Rm selected by one-hot `nsel`. `nsel` = 000 or any non-one-hot value → 000.
- All control inputs act independently in one cycle. `load_ir`+`load_pc`, and `load_addr`+`PC_sel` (both sample the same `datapath_out`), all take effect.
- Reset values while `reset` is low: `pc` = RESET_PC, data address = 0, IR = 16'h0000. Consequently `opcode`/`op`/`cond` = 0, immediates = 0, `shift` = 0, and `mem_addr` = RESET_PC when `addr_sel` = 1, else 0.
- Reset asserted mid-instruction (for example during a branch): registers clear immediately, asynchronously. No pending load survives. Release is synchronous to the next edge.

## Timing
- Register latency is one cycle: a load asserted in cycle N is visible on outputs in cycle N+1.
- `mem_addr` and decode outputs have zero-cycle combinational paths from registers, `addr_sel` and `nsel`.
- Fetch sequence as driven by the controller:
  - IF1: `addr_sel`=1; `mem_addr` = PC.
  - IF2: `load_ir`=1; IR holds the new instruction from the IF2 edge.
  - UpdatePC: `load_pc`=1; PC = PC+1.
  - Decode state: sees the new `opcode`/`op`/`cond` and the incremented PC.
- Branch: `PC_sel` can be held for several cycles. The PC tracks `datapath_out` every cycle and the last edge's value wins.

## Structure
- Shared package `riscm_pkg` holds:
  - ADDR_W and RESET_PC defaults.
  - Opcode constants: MOV 110, ALU 101, LDR 011, STR 100, HALT 111, B 001.
  - Cond codes: B 000, BEQ 001, BNE 010, BLT 011, BLE 100.
  - `nsel` one-hot codes.
  - `mem_cmd` codes: NONE 00, READ 01, WRITE 10.
- One sub-module, `instr_decoder`: purely combinational IR → fields, including the `nsel` mux and the shift override. The three registers and the address mux stay in the top module.

## Test plan
- Reset: hold `reset`=0 mid-run with `pc`=0x0A5 and IR=16'hFFFF → `pc`=0, IR=0, and `mem_addr`=0 with `addr_sel`=1, all before the next clock edge.
- MOV decode: `mdata`=16'hD2A5, `load_ir` pulse → `opcode`=110, `op`=10, `sximm8`=16'hFFA5; with `nsel`=001, `readnum`=2.
- LDR decode and address path:
  - `mdata`=16'h6151, `load_ir` pulse → `sximm5`=16'hFFF1 and `shift`=00 (not 10); with `nsel`=010, `writenum`=2.
  - Then `load_addr` with `datapath_out`=16'h01F5 and `addr_sel`=0 → `mem_addr`=0x1F5.
- PC wrap: `pc`=511, `load_pc` pulse → `pc`=0.
- Branch priority:
  - `PC_sel`=1 with `datapath_out`=16'h0123 → `pc`=0x123.
  - `PC_sel`=1 with `reset_pc`=1 in the same cycle → `pc`=0.
  - `PC_sel` held two cycles with `datapath_out` changing 0x010 → 0x020 → `pc`=0x020.
- `nsel` illegal value 011 → `readnum`=0; all registers unchanged when every load input is 0 for 10 cycles.
